// File: rtl/agu_lsu_front_pkg.sv
// Shared widths, encodings and helpers for the AGU/LSU front end.
package agu_lsu_front_pkg;

  localparam int AGU_XLEN            = 32;
  localparam int AGU_DTCM_ADDR_WIDTH = 16;
  localparam int AGU_ITAG_WIDTH      = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } mem_size_e;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_REGION   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_EXC   = 2'b11
  } agu_state_e;

  // Reserved size encoding is treated as a misaligned access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofst);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = ofst[0];
      SZ_WORD: is_misaligned = |ofst;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/agu_lsu_front_lane_align.sv
// Store byte-enable generation and lane replication of store data.
module agu_lane_align
  import agu_lsu_front_pkg::*;
#(
  parameter int XLEN = AGU_XLEN
) (
  input  logic [1:0]        size,
  input  logic [1:0]        ofst,
  input  logic              load,
  input  logic [XLEN-1:0]   rs2,
  output logic [XLEN/8-1:0] wmask,
  output logic [XLEN-1:0]   wdata
);

  localparam int NB = XLEN / 8;

  always_comb begin
    wmask = '0;
    wdata = '0;
    if (!load) begin
      case (size)
        SZ_BYTE: begin
          wmask = NB'(1) << ofst;
          wdata = {NB{rs2[7:0]}};
        end
        SZ_HALF: begin
          wmask = NB'(3) << ofst;
          wdata = {(XLEN/16){rs2[15:0]}};
        end
        SZ_WORD: begin
          wmask = '1;
          wdata = rs2;
        end
        default: begin
          wmask = '0;
          wdata = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/agu_lsu_front.sv
// Address generation and LSU command front end: one op in flight, with
// alignment/region checks that divert faulting ops to an exception port.
module agu_lsu_front
  import agu_lsu_front_pkg::*;
#(
  parameter int              XLEN            = AGU_XLEN,
  parameter int              DTCM_ADDR_WIDTH = AGU_DTCM_ADDR_WIDTH,
  parameter int              ITAG_WIDTH      = AGU_ITAG_WIDTH,
  parameter logic [XLEN-1:0] DTCM_BASE       = XLEN'(32'h8000_0000)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic                       disp_load,
  input  logic [1:0]                 disp_size,
  input  logic                       disp_unsigned,
  input  logic [XLEN-1:0]            disp_rs1,
  input  logic [XLEN-1:0]            disp_rs2,
  input  logic [XLEN-1:0]            disp_imm,
  input  logic [ITAG_WIDTH-1:0]      disp_itag,
  output logic                       agu_cmd_valid,
  input  logic                       agu_cmd_ready,
  output logic                       agu_cmd_read,
  output logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr,
  output logic [XLEN-1:0]            agu_cmd_wdata,
  output logic [XLEN/8-1:0]          agu_cmd_wmask,
  output logic [ITAG_WIDTH-1:0]      agu_cmd_itag,
  input  logic                       agu_rsp_valid,
  output logic                       agu_rsp_ready,
  output logic [1:0]                 ld_size,
  output logic                       ld_unsigned,
  output logic [1:0]                 ld_ofst,
  output logic                       exc_valid,
  input  logic                       exc_ready,
  output logic [1:0]                 exc_cause,
  output logic                       exc_load,
  output logic [ITAG_WIDTH-1:0]      exc_itag,
  output logic [XLEN-1:0]            exc_badaddr
);

  agu_state_e state_q, state_d;

  logic                  hs;
  logic [XLEN-1:0]       sum;
  logic                  misaligned;
  logic                  out_of_region;
  logic                  fault;

  logic                  r_load;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [XLEN-1:0]       r_sum;
  logic [XLEN-1:0]       r_rs2;
  logic [ITAG_WIDTH-1:0] r_itag;
  logic [1:0]            r_cause;

  logic [XLEN/8-1:0]     lane_wmask;
  logic [XLEN-1:0]       lane_wdata;

  assign hs            = disp_valid && (state_q == ST_IDLE);
  assign sum           = disp_rs1 + disp_imm;
  assign misaligned    = is_misaligned(disp_size, sum[1:0]);
  assign out_of_region = sum[XLEN-1:DTCM_ADDR_WIDTH] != DTCM_BASE[XLEN-1:DTCM_ADDR_WIDTH];
  assign fault         = misaligned || out_of_region;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hs) state_d = fault ? ST_EXC : ST_ISSUE;
      ST_ISSUE: if (agu_cmd_ready) state_d = ST_WAIT;
      ST_WAIT:  if (agu_rsp_valid) state_d = ST_IDLE;
      ST_EXC:   if (exc_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Op fields are captured for every accepted op, faulting or not, and held
  // until the next acceptance so write-back and exception info stay stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load     <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_sum      <= '0;
      r_rs2      <= '0;
      r_itag     <= '0;
      r_cause    <= CAUSE_NONE;
    end else if (hs) begin
      r_load     <= disp_load;
      r_size     <= disp_size;
      r_unsigned <= disp_unsigned;
      r_sum      <= sum;
      r_rs2      <= disp_rs2;
      r_itag     <= disp_itag;
      r_cause    <= misaligned ? CAUSE_MISALIGN : (out_of_region ? CAUSE_REGION : CAUSE_NONE);
    end
  end

  agu_lane_align #(
    .XLEN(XLEN)
  ) u_lane_align (
    .size  (r_size),
    .ofst  (r_sum[1:0]),
    .load  (r_load),
    .rs2   (r_rs2),
    .wmask (lane_wmask),
    .wdata (lane_wdata)
  );

  assign disp_ready    = (state_q == ST_IDLE);
  assign agu_cmd_valid = (state_q == ST_ISSUE);
  assign agu_rsp_ready = (state_q == ST_WAIT);
  assign exc_valid     = (state_q == ST_EXC);

  assign agu_cmd_read  = r_load;
  assign agu_cmd_addr  = r_sum[DTCM_ADDR_WIDTH-1:0];
  assign agu_cmd_itag  = r_itag;
  // Lane data is only meaningful while a command is offered.
  assign agu_cmd_wmask = agu_cmd_valid ? lane_wmask : '0;
  assign agu_cmd_wdata = agu_cmd_valid ? lane_wdata : '0;

  assign ld_size       = r_size;
  assign ld_unsigned   = r_unsigned;
  assign ld_ofst       = r_sum[1:0];

  assign exc_cause     = r_cause;
  assign exc_load      = r_load;
  assign exc_itag      = r_itag;
  assign exc_badaddr   = r_sum;

endmodule

// File: tb/tb_agu_lsu_front.sv
// Directed bench for agu_lsu_front with hand-computed expectations.
module tb_agu_lsu_front;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready, disp_load, disp_unsigned;
  logic [1:0]  disp_size;
  logic [31:0] disp_rs1, disp_rs2, disp_imm;
  logic [3:0]  disp_itag;
  logic        agu_cmd_valid, agu_cmd_ready, agu_cmd_read;
  logic [15:0] agu_cmd_addr;
  logic [31:0] agu_cmd_wdata;
  logic [3:0]  agu_cmd_wmask, agu_cmd_itag;
  logic        agu_rsp_valid, agu_rsp_ready;
  logic [1:0]  ld_size, ld_ofst;
  logic        ld_unsigned;
  logic        exc_valid, exc_ready, exc_load;
  logic [1:0]  exc_cause;
  logic [3:0]  exc_itag;
  logic [31:0] exc_badaddr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  agu_lsu_front dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_load(disp_load),
    .disp_size(disp_size), .disp_unsigned(disp_unsigned), .disp_rs1(disp_rs1),
    .disp_rs2(disp_rs2), .disp_imm(disp_imm), .disp_itag(disp_itag),
    .agu_cmd_valid(agu_cmd_valid), .agu_cmd_ready(agu_cmd_ready),
    .agu_cmd_read(agu_cmd_read), .agu_cmd_addr(agu_cmd_addr),
    .agu_cmd_wdata(agu_cmd_wdata), .agu_cmd_wmask(agu_cmd_wmask),
    .agu_cmd_itag(agu_cmd_itag), .agu_rsp_valid(agu_rsp_valid),
    .agu_rsp_ready(agu_rsp_ready), .ld_size(ld_size), .ld_unsigned(ld_unsigned),
    .ld_ofst(ld_ofst), .exc_valid(exc_valid), .exc_ready(exc_ready),
    .exc_cause(exc_cause), .exc_load(exc_load), .exc_itag(exc_itag),
    .exc_badaddr(exc_badaddr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic ld, input logic [1:0] sz, input logic uns,
                       input logic [31:0] rs1, input logic [31:0] imm,
                       input logic [31:0] rs2, input logic [3:0] tag);
    disp_valid = 1'b1; disp_load = ld; disp_size = sz; disp_unsigned = uns;
    disp_rs1 = rs1; disp_imm = imm; disp_rs2 = rs2; disp_itag = tag;
  endtask

  task automatic idle_inputs();
    disp_valid = 1'b0; disp_load = 1'b0; disp_size = 2'b00; disp_unsigned = 1'b0;
    disp_rs1 = '0; disp_imm = '0; disp_rs2 = '0; disp_itag = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    agu_cmd_ready = 1'b0; agu_rsp_valid = 1'b0; exc_ready = 1'b0;
    step();
    step();
    chk("rst_cmd_valid", agu_cmd_valid, 0);
    chk("rst_rsp_ready", agu_rsp_ready, 0);
    rst = 1'b0;
    step();
    chk("rst_disp_ready", disp_ready, 1);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_addr", agu_cmd_addr, 0);
    chk("rst_wmask", agu_cmd_wmask, 0);
    chk("rst_wdata", agu_cmd_wdata, 0);
    chk("rst_badaddr", exc_badaddr, 0);
    chk("rst_cause", exc_cause, 0);

    // Store byte to 0x8000_0003
    offer(1'b0, 2'b00, 1'b0, 32'h8000_0000, 32'h3, 32'h1234_56AB, 4'h5);
    chk("sb_ready_at_hs", disp_ready, 1);
    step();
    idle_inputs();
    chk("sb_cmd_valid", agu_cmd_valid, 1);
    chk("sb_addr", agu_cmd_addr, 16'h0003);
    chk("sb_wmask", agu_cmd_wmask, 4'b1000);
    chk("sb_wdata", agu_cmd_wdata, 32'hABAB_ABAB);
    chk("sb_read", agu_cmd_read, 0);
    chk("sb_itag", agu_cmd_itag, 4'h5);
    chk("sb_disp_ready", disp_ready, 0);
    agu_cmd_ready = 1'b1;
    step();
    agu_cmd_ready = 1'b0;
    chk("sb_wait_rsp_ready", agu_rsp_ready, 1);
    chk("sb_wait_cmd_valid", agu_cmd_valid, 0);
    agu_rsp_valid = 1'b1;
    step();
    agu_rsp_valid = 1'b0;
    chk("sb_back_idle", disp_ready, 1);

    // Load half, unsigned, 0x8000_0010 - 2, with a 3-cycle command stall
    offer(1'b1, 2'b01, 1'b1, 32'h8000_0010, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 4'h9);
    step();
    idle_inputs();
    chk("lh_cmd_valid", agu_cmd_valid, 1);
    chk("lh_addr", agu_cmd_addr, 16'h000E);
    chk("lh_wmask", agu_cmd_wmask, 0);
    chk("lh_wdata", agu_cmd_wdata, 0);
    chk("lh_read", agu_cmd_read, 1);
    chk("lh_ld_size", ld_size, 2'b01);
    chk("lh_ld_unsigned", ld_unsigned, 1);
    chk("lh_ld_ofst", ld_ofst, 2'd2);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_cmd_valid", agu_cmd_valid, 1);
      chk("stall_addr", agu_cmd_addr, 16'h000E);
      chk("stall_itag", agu_cmd_itag, 4'h9);
      chk("stall_disp_ready", disp_ready, 0);
    end
    agu_cmd_ready = 1'b1;
    step();
    agu_cmd_ready = 1'b0;
    chk("lh_wait_rsp_ready", agu_rsp_ready, 1);
    chk("lh_wait_ofst", ld_ofst, 2'd2);
    step();
    chk("lh_wait_hold", agu_rsp_ready, 1);
    chk("lh_wait_disp_ready", disp_ready, 0);
    agu_rsp_valid = 1'b1;
    step();
    agu_rsp_valid = 1'b0;
    chk("lh_exit_disp_ready", disp_ready, 1);
    chk("lh_exit_rsp_ready", agu_rsp_ready, 0);

    // Stray response while idle must not disturb the FSM
    agu_rsp_valid = 1'b1;
    step();
    agu_rsp_valid = 1'b0;
    chk("stray_rsp_idle", disp_ready, 1);
    chk("stray_rsp_cmd", agu_cmd_valid, 0);

    // Misaligned load word at 0x8000_0006
    offer(1'b1, 2'b10, 1'b0, 32'h8000_0000, 32'h6, 32'h0, 4'h3);
    step();
    idle_inputs();
    chk("mis_exc_valid", exc_valid, 1);
    chk("mis_cmd_valid", agu_cmd_valid, 0);
    chk("mis_cause", exc_cause, 2'b01);
    chk("mis_badaddr", exc_badaddr, 32'h8000_0006);
    chk("mis_load", exc_load, 1);
    chk("mis_itag", exc_itag, 4'h3);
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;
    chk("mis_exit_exc", exc_valid, 0);
    chk("mis_exit_cmd", agu_cmd_valid, 0);
    chk("mis_exit_ready", disp_ready, 1);

    // Out-of-region store word to 0x9000_0000, exception held 5 cycles
    offer(1'b0, 2'b10, 1'b0, 32'h9000_0000, 32'h0, 32'h5555_AAAA, 4'h7);
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      chk("oor_exc_valid", exc_valid, 1);
      chk("oor_cause", exc_cause, 2'b10);
      chk("oor_badaddr", exc_badaddr, 32'h9000_0000);
      chk("oor_itag", exc_itag, 4'h7);
      chk("oor_load", exc_load, 0);
      chk("oor_disp_ready", disp_ready, 0);
      chk("oor_cmd_valid", agu_cmd_valid, 0);
      step();
    end
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;
    chk("oor_exit", disp_ready, 1);

    // Reserved size out of region: misaligned wins
    offer(1'b1, 2'b11, 1'b0, 32'h9000_0000, 32'h0, 32'h0, 4'h2);
    step();
    idle_inputs();
    chk("prio_exc_valid", exc_valid, 1);
    chk("prio_cause", exc_cause, 2'b01);
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;

    // Last word of the region is legal; first byte past it is not
    offer(1'b1, 2'b10, 1'b0, 32'h8000_FFF0, 32'hC, 32'h0, 4'h1);
    step();
    chk("edge_cmd_valid", agu_cmd_valid, 1);
    chk("edge_addr", agu_cmd_addr, 16'hFFFC);
    offer(1'b1, 2'b10, 1'b0, 32'h8000_FFF0, 32'h10, 32'h0, 4'h1);
    step();
    chk("edge_no_accept_in_issue", agu_cmd_addr, 16'hFFFC);
    idle_inputs();
    agu_cmd_ready = 1'b1;
    step();
    agu_cmd_ready = 1'b0;
    agu_rsp_valid = 1'b1;
    step();
    agu_rsp_valid = 1'b0;
    offer(1'b0, 2'b00, 1'b0, 32'h8001_0000, 32'h0, 32'h0, 4'h1);
    step();
    idle_inputs();
    chk("past_end_exc", exc_valid, 1);
    chk("past_end_cause", exc_cause, 2'b10);
    exc_ready = 1'b1;
    step();
    exc_ready = 1'b0;

    // Store half to 0x8000_0002, then reset while waiting for the response
    offer(1'b0, 2'b01, 1'b0, 32'h8000_0000, 32'h2, 32'hCAFE_BEEF, 4'hA);
    step();
    idle_inputs();
    chk("sh_wmask", agu_cmd_wmask, 4'b1100);
    chk("sh_wdata", agu_cmd_wdata, 32'hBEEF_BEEF);
    agu_cmd_ready = 1'b1;
    step();
    agu_cmd_ready = 1'b0;
    chk("sh_wait", agu_rsp_ready, 1);
    rst = 1'b1;
    agu_rsp_valid = 1'b1;
    step();
    chk("mrst_disp_ready", disp_ready, 1);
    chk("mrst_rsp_ready", agu_rsp_ready, 0);
    chk("mrst_cmd_valid", agu_cmd_valid, 0);
    chk("mrst_exc_valid", exc_valid, 0);
    chk("mrst_addr", agu_cmd_addr, 0);
    chk("mrst_wdata", agu_cmd_wdata, 0);
    chk("mrst_itag", agu_cmd_itag, 0);
    chk("mrst_ld_size", ld_size, 0);
    chk("mrst_badaddr", exc_badaddr, 0);
    rst = 1'b0;
    step();
    agu_rsp_valid = 1'b0;
    chk("mrst_stale_rsp", disp_ready, 1);
    chk("mrst_stale_rsp_ready", agu_rsp_ready, 0);

    // Store word after reset: full mask and unreplicated data
    offer(1'b0, 2'b10, 1'b0, 32'h8000_0100, 32'h4, 32'h0102_0304, 4'hF);
    step();
    idle_inputs();
    chk("sw_addr", agu_cmd_addr, 16'h0104);
    chk("sw_wmask", agu_cmd_wmask, 4'b1111);
    chk("sw_wdata", agu_cmd_wdata, 32'h0102_0304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
